mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares a single synchronous RAM port between instruction fetch (master 0) and load/store (master 1).
- All ports use the core's req/addr_ok/data_ok RAM protocol.
- Tracks outstanding accepted requests in an in-order ID FIFO so each slave data_ok/rdata goes back to the master that issued it.
- Sits between the core and the unified memory for configurations with one shared RAM.

Parameters:
- XLEN, 32, data/address width.
- OUTSTANDING, 2, maximum accepted-but-unanswered requests (ID FIFO depth, power of two, >=1).
- RR_MODE, 0, 0 = fixed priority (master 1 wins); 1 = round-robin between masters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m0_req  in  1  master 0 request
- m0_write  in  1  master 0 write
- m0_wstrb  in  XLEN/8  master 0 byte strobes
- m0_addr  in  XLEN  master 0 address
- m0_wdata  in  XLEN  master 0 write data
- m0_addr_ok  out  1  master 0 request accepted
- m0_data_ok  out  1  master 0 response valid
- m0_rdata  out  XLEN  master 0 read data
- m1_req, m1_write, m1_wstrb, m1_addr, m1_wdata, m1_addr_ok, m1_data_ok, m1_rdata: same as m0_* for master 1
- s_req  out  1  slave request
- s_write  out  1  slave write
- s_wstrb  out  XLEN/8  slave byte strobes
- s_addr  out  XLEN  slave address
- s_wdata  out  XLEN  slave write data
- s_addr_ok  in  1  slave accepted request
- s_data_ok  in  1  slave response valid
- s_rdata  in  XLEN  slave read data

Behaviour:
- Protocol:
  - A handshake occurs on a cycle with req & addr_ok.
  - A master holds req and its payload stable until the handshake.
  - The slave returns exactly one data_ok per handshake, in order, no earlier than the cycle after the handshake (writes included).
- Reset (async, rst=1):
  - Clears FIFO count, read/write pointers, lock and the rr pointer (master 0 next).
  - While rst=1, all outputs are forced to 0 (s_req, addr_ok, data_ok, rdata).
- Grant:
  - If lock=1, grant = locked master.
  - Otherwise, with only one master requesting, that master wins.
  - With both requesting: RR_MODE=0 gives master 1; RR_MODE=1 gives the master indicated by the rr pointer.
  - No requesters: no grant, s_req=0.
- Lock:
  - Set when s_req=1 & s_addr_ok=0, recording the granted master.
  - Cleared on the handshake.
  - The slave therefore never sees req/payload switch masters mid-request.
- rr pointer: on each handshake, points to the master that was not granted.
- Slave request:
  - s_req = granted master's req & (count < OUTSTANDING).
  - s_write/s_wstrb/s_addr/s_wdata are muxed from the granted master (master 0 when idle).
  - When full, s_req=0 even if a pop occurs the same cycle (no full bypass).
  - The lock is not set while blocked by full.
- Accept: m<g>_addr_ok = s_addr_ok & s_req & (grant==g). The non-granted master's addr_ok=0.
- ID FIFO:
  - On a handshake, push the granted ID.
  - On s_data_ok, pop the head ID.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo OUTSTANDING.
- Response:
  - m<h>_data_ok = s_data_ok where h = head ID; the other master's data_ok=0.
  - Both m0_rdata and m1_rdata = s_rdata combinationally, with zero added latency.
- Error: s_data_ok with count==0 is a protocol violation. Ignore it (no pop, both data_ok=0) and fire a simulation assertion.
- Reset mid-operation: outstanding IDs are discarded. A later stray s_data_ok falls under the error rule.
- Latency: zero-cycle combinational path master→slave and slave→master; no added pipeline stage.

Test Plan:
- Only m0 requests addr 0x0,0x4,0x8 back-to-back, slave always addr_ok and data_ok one cycle later → m0_addr_ok each cycle, 3 m0_data_ok with matching rdata, m1 outputs 0.
- Both request in the same cycle, RR_MODE=0 → m1 accepted first, m0 next cycle; data_ok order m1 then m0.
- Both request continuously, RR_MODE=1 → grants alternate 0,1,0,1 and data_ok IDs follow the same order.
- m0 requests and slave holds addr_ok=0 for 3 cycles while m1 raises req in cycle 1 → s_addr stays m0's address for all 3 cycles; m0 accepted before m1.
- OUTSTANDING=2, slave withholds data_ok → after 2 handshakes s_req=0; first s_data_ok pops, s_req re-asserts next cycle.
- Assert rst with 1 outstanding, then a stray s_data_ok → no m*_data_ok, assertion fires, count stays 0.

Source files
------------

// File: rtl/mem_if.sv
// mem_if: one req/addr_ok/data_ok RAM port.
//   master modport: drives req, write, wstrb, addr, wdata; receives addr_ok, data_ok, rdata.
//   slave modport : receives req, write, wstrb, addr, wdata; drives addr_ok, data_ok, rdata.
interface mem_if #(
   parameter int unsigned XLEN = 32
);
   logic                  req;
   logic                  write;
   logic [XLEN/8-1:0]     wstrb;
   logic [XLEN-1:0]       addr;
   logic [XLEN-1:0]       wdata;
   logic                  addr_ok;
   logic                  data_ok;
   logic [XLEN-1:0]       rdata;

   modport master (
      output req, write, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, write, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch (m0) and load/store (m1).
//   clk, rst : clock, asynchronous active-high reset
//   m0, m1   : master-side ports (arbiter acts as their slave)
//   s        : shared RAM port (arbiter acts as its master)
// Accepted requests are tracked in an in-order ID FIFO so each response is routed
// back to the master that issued it. All data paths are combinational.
module mem_arbiter #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned OUTSTANDING = 2,
   parameter bit          RR_MODE     = 1'b0
) (
   input  logic   clk,
   input  logic   rst,
   mem_if.slave   m0,
   mem_if.slave   m1,
   mem_if.master  s
);

   localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

   logic [CNT_W-1:0]       count_q, count_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [OUTSTANDING-1:0] id_q, id_d;
   logic                   lock_q, lock_d;
   logic                   lock_id_q, lock_id_d;
   logic                   rr_q, rr_d;

   logic grant_c;      // 0 = m0, 1 = m1 (0 when idle)
   logic gnt_req_c;
   logic s_req_c;
   logic hs_c;
   logic pop_c;
   logic head_id_c;
   logic stray_dok_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Grant selection: a locked request keeps its master until accepted
   always_comb begin
      grant_c = 1'b0;
      if (lock_q) begin
         grant_c = lock_id_q;
      end else if (m0.req && m1.req) begin
         grant_c = RR_MODE ? rr_q : 1'b1;
      end else if (m1.req) begin
         grant_c = 1'b1;
      end
   end

   // Handshake / response qualification; full blocks s_req even on a same-cycle pop
   always_comb begin
      gnt_req_c   = grant_c ? m1.req : m0.req;
      s_req_c     = gnt_req_c && (count_q < CNT_MAX) && !rst;
      hs_c        = s_req_c && s.addr_ok;
      head_id_c   = id_q[rd_ptr_q];
      pop_c       = s.data_ok && (count_q != '0) && !rst;
      stray_dok_c = s.data_ok && (count_q == '0) && !rst;
   end

   // Slave-side request and payload mux
   assign s.req   = s_req_c;
   assign s.write = grant_c ? m1.write : m0.write;
   assign s.wstrb = grant_c ? m1.wstrb : m0.wstrb;
   assign s.addr  = grant_c ? m1.addr  : m0.addr;
   assign s.wdata = grant_c ? m1.wdata : m0.wdata;

   // Master-side accept and response routing
   assign m0.addr_ok = hs_c && !grant_c;
   assign m1.addr_ok = hs_c &&  grant_c;
   assign m0.data_ok = pop_c && !head_id_c;
   assign m1.data_ok = pop_c &&  head_id_c;
   assign m0.rdata   = rst ? {XLEN{1'b0}} : s.rdata;
   assign m1.rdata   = rst ? {XLEN{1'b0}} : s.rdata;

   // Next-state: ID FIFO, lock and round-robin pointer
   always_comb begin
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      id_d      = id_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      rr_d      = rr_q;

      if (hs_c) begin
         id_d[wr_ptr_q] = grant_c;
         wr_ptr_d       = ptr_inc(wr_ptr_q);
         lock_d         = 1'b0;
         rr_d           = ~grant_c;
      end else if (s_req_c) begin
         lock_d    = 1'b1;
         lock_id_d = grant_c;
      end

      if (pop_c) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      case ({hs_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         id_q      <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         rr_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         id_q      <= id_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         rr_q      <= rr_d;
      end
   end

   // A response with nothing outstanding is dropped; flag it in simulation
   a_no_stray_dok: assert property (@(posedge clk) disable iff (rst) !stray_dok_c)
      else $warning("mem_arbiter: s_data_ok with no outstanding request ignored");

endmodule
